// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter that shares one memory port among NUM_PORTS requesters.
// One transaction is outstanding at a time, and each wait for a response is bounded by a watchdog.
module core_mem_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int TIMEOUT      = 1024
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               req_read,
  input  logic [NUM_PORTS-1:0]               req_write,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  req_byte_en,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0]  req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_PORTS-1:0]               grant,
  output logic [NUM_PORTS-1:0]               resp_valid,
  output logic                               resp_error,
  output logic [DATA_WIDTH-1:0]              resp_data,
  output logic [ADDRESS_BITS-1:0]            resp_address,
  output logic                               mem_read,
  output logic                               mem_write,
  output logic [DATA_WIDTH/8-1:0]            mem_byte_en,
  output logic [ADDRESS_BITS-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]              mem_data_out,
  input  logic                               mem_ready,
  input  logic                               mem_valid,
  input  logic [DATA_WIDTH-1:0]              mem_data_in,
  input  logic [ADDRESS_BITS-1:0]            mem_address_in,
  output logic                               busy
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        last_q;
  logic [NUM_PORTS-1:0]    grant_q;
  logic [NUM_PORTS-1:0]    resp_valid_q;
  logic                    resp_error_q;
  logic [DATA_WIDTH-1:0]   resp_data_q;
  logic [ADDRESS_BITS-1:0] resp_addr_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [BE_W-1:0]         mem_be_q;
  logic [ADDRESS_BITS-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [CNT_W-1:0]        count_q;

  logic [NUM_PORTS-1:0]    req_any;
  logic [BE_W-1:0]         be_arr   [NUM_PORTS];
  logic [ADDRESS_BITS-1:0] addr_arr [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   data_arr [NUM_PORTS];
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        cand;

  assign req_any = req_read | req_write;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign be_arr[g]   = req_byte_en[g*BE_W +: BE_W];
    assign addr_arr[g] = req_address[g*ADDRESS_BITS +: ADDRESS_BITS];
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requester found searching upward from the port after the last owner, with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_PORTS);
      if (!pick_found && req_any[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= IDX_W'(NUM_PORTS - 1);
      grant_q      <= '0;
      resp_valid_q <= '0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
      resp_addr_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q     <= ISSUE;
            last_q      <= pick_idx;
            grant_q     <= ONE_HOT0 << pick_idx;
            mem_write_q <= req_write[pick_idx];
            mem_read_q  <= ~req_write[pick_idx];
            mem_be_q    <= be_arr[pick_idx];
            mem_addr_q  <= addr_arr[pick_idx];
            mem_wdata_q <= data_arr[pick_idx];
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            state_q     <= WAIT;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            count_q     <= '0;
          end
        end
        WAIT: begin
          // A response arriving in the same cycle as the timeout still wins.
          if (mem_valid) begin
            state_q      <= RELEASE;
            resp_valid_q <= grant_q;
            resp_error_q <= 1'b0;
            resp_data_q  <= mem_data_in;
            resp_addr_q  <= mem_address_in;
          end else if (TIMEOUT != 0 && count_q == CNT_W'(TIMEOUT)) begin
            state_q      <= RELEASE;
            resp_valid_q <= grant_q;
            resp_error_q <= 1'b1;
            resp_data_q  <= '0;
            resp_addr_q  <= mem_addr_q;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          state_q      <= IDLE;
          resp_valid_q <= '0;
          grant_q      <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant        = grant_q;
  assign resp_valid   = resp_valid_q;
  assign resp_error   = resp_error_q;
  assign resp_data    = resp_data_q;
  assign resp_address = resp_addr_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_byte_en  = mem_be_q;
  assign mem_address  = mem_addr_q;
  assign mem_data_out = mem_wdata_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed testbench for core_mem_arbiter: 4 ports and a short watchdog, with expected values written by hand.
module tb_core_mem_arbiter;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    reqRead, reqWrite;
  logic [15:0]   reqByteEn;
  logic [127:0]  reqAddress, reqData;
  logic [3:0]    grant, respValid;
  logic          respError;
  logic [31:0]   respData, respAddress;
  logic          memRead, memWrite;
  logic [3:0]    memByteEn;
  logic [31:0]   memAddress, memDataOut;
  logic          memReady, memValid;
  logic [31:0]   memDataIn, memAddressIn;
  logic          busy;

  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] portAddr [4];

  core_mem_arbiter #(
    .NUM_PORTS(4), .DATA_WIDTH(32), .ADDRESS_BITS(32), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_read(reqRead), .req_write(reqWrite), .req_byte_en(reqByteEn),
    .req_address(reqAddress), .req_data(reqData),
    .grant(grant), .resp_valid(respValid), .resp_error(respError),
    .resp_data(respData), .resp_address(respAddress),
    .mem_read(memRead), .mem_write(memWrite), .mem_byte_en(memByteEn),
    .mem_address(memAddress), .mem_data_out(memDataOut),
    .mem_ready(memReady), .mem_valid(memValid),
    .mem_data_in(memDataIn), .mem_address_in(memAddressIn),
    .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int p, input logic rd, input logic wr, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] data);
    reqRead[p]              = rd;
    reqWrite[p]             = wr;
    reqByteEn[p*4 +: 4]     = be;
    reqAddress[p*32 +: 32]  = addr;
    reqData[p*32 +: 32]     = data;
    portAddr[p]             = addr;
  endtask

  // From IDLE: grant to expPort, accept at once, respond in the first WAIT cycle, back to IDLE.
  task automatic serveOne(input int expPort, input logic [31:0] rdata, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << expPort;
    tick();
    checkOutput({tag, " grant"}, 64'(grant), 64'(oh));
    checkOutput({tag, " mem_address"}, 64'(memAddress), 64'(portAddr[expPort]));
    memReady = 1'b1;
    tick();
    memReady     = 1'b0;
    memValid     = 1'b1;
    memDataIn    = rdata;
    memAddressIn = portAddr[expPort];
    tick();
    checkOutput({tag, " resp_valid"}, 64'(respValid), 64'(oh));
    checkOutput({tag, " resp_data"}, 64'(respData), 64'(rdata));
    checkOutput({tag, " resp_error"}, 64'(respError), 64'(0));
    memValid = 1'b0;
    tick();
    checkOutput({tag, " busy idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    reqRead = '0; reqWrite = '0; reqByteEn = '0; reqAddress = '0; reqData = '0;
    memReady = 1'b0; memValid = 1'b0; memDataIn = '0; memAddressIn = '0;
    for (int i = 0; i < 4; i++) portAddr[i] = '0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset grant", 64'(grant), 64'(0));
    checkOutput("reset resp_valid", 64'(respValid), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset mem_read", 64'(memRead), 64'(0));
    checkOutput("reset mem_write", 64'(memWrite), 64'(0));
    checkOutput("reset resp_data", 64'(respData), 64'(0));

    // Single read on port 2; memory answers 3 cycles after accept.
    applyStimulus(2, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    memReady = 1'b1;
    tick();
    checkOutput("rd grant", 64'(grant), 64'(4'b0100));
    checkOutput("rd mem_read", 64'(memRead), 64'(1));
    checkOutput("rd mem_address", 64'(memAddress), 64'(32'h40));
    checkOutput("rd busy", 64'(busy), 64'(1));
    tick();
    memReady = 1'b0;
    checkOutput("rd strobe dropped", 64'(memRead), 64'(0));
    tick();
    checkOutput("rd no early resp", 64'(respValid), 64'(0));
    tick();
    memValid = 1'b1; memDataIn = 32'hDEADBEEF; memAddressIn = 32'h40;
    tick();
    checkOutput("rd resp_valid", 64'(respValid), 64'(4'b0100));
    checkOutput("rd resp_data", 64'(respData), 64'(32'hDEADBEEF));
    checkOutput("rd resp_address", 64'(respAddress), 64'(32'h40));
    checkOutput("rd resp_error", 64'(respError), 64'(0));
    memValid = 1'b0;
    reqRead[2] = 1'b0;
    tick();
    checkOutput("rd pulse one cycle", 64'(respValid), 64'(0));
    checkOutput("rd grant cleared", 64'(grant), 64'(0));

    // All four ports from reset, then only ports 0 and 3.
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 1'b0, 4'hF, 32'h1000 + 32'(i * 16), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    serveOne(0, 32'hA0, "rr0");
    serveOne(1, 32'hA1, "rr1");
    serveOne(2, 32'hA2, "rr2");
    serveOne(3, 32'hA3, "rr3");
    reqRead = 4'b1001;
    serveOne(0, 32'hB0, "pair0");
    serveOne(3, 32'hB3, "pair3");
    serveOne(0, 32'hC0, "pair0b");
    serveOne(3, 32'hC3, "pair3b");
    reqRead = 4'b0000;

    // Write on port 1 held off by mem_ready for 5 cycles.
    applyStimulus(1, 1'b0, 1'b1, 4'b0011, 32'h2000, 32'h1234);
    tick();
    checkOutput("wr grant", 64'(grant), 64'(4'b0010));
    checkOutput("wr mem_read", 64'(memRead), 64'(0));
    reqAddress[32 +: 32] = 32'hFFFF;
    reqData[32 +: 32]    = 32'h5555;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) memReady = 1'b1;
      checkOutput("wr mem_write held", 64'(memWrite), 64'(1));
      checkOutput("wr address stable", 64'(memAddress), 64'(32'h2000));
      checkOutput("wr data stable", 64'(memDataOut), 64'(32'h1234));
      checkOutput("wr byte_en stable", 64'(memByteEn), 64'(4'b0011));
      tick();
    end
    memReady = 1'b0;
    checkOutput("wr strobe dropped", 64'(memWrite), 64'(0));
    memValid = 1'b1;
    tick();
    checkOutput("wr resp_valid", 64'(respValid), 64'(4'b0010));
    checkOutput("wr resp_error", 64'(respError), 64'(0));
    memValid = 1'b0;
    reqWrite[1] = 1'b0;
    tick();

    // Read and write both requested on port 0: write wins.
    applyStimulus(0, 1'b1, 1'b1, 4'hF, 32'h3000, 32'h77);
    tick();
    checkOutput("rw grant", 64'(grant), 64'(4'b0001));
    checkOutput("rw mem_write", 64'(memWrite), 64'(1));
    checkOutput("rw mem_read", 64'(memRead), 64'(0));
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    memValid = 1'b1;
    tick();
    checkOutput("rw resp_valid", 64'(respValid), 64'(4'b0001));
    memValid = 1'b0;
    reqRead[0] = 1'b0; reqWrite[0] = 1'b0;
    tick();

    // Watchdog: no mem_valid, response with error exactly 9 cycles after WAIT entry.
    applyStimulus(3, 1'b1, 1'b0, 4'hF, 32'h4000, 32'h0);
    memDataIn = 32'h13579BDF;
    tick();
    checkOutput("to grant", 64'(grant), 64'(4'b1000));
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checkOutput("to no early resp", 64'(respValid), 64'(0));
    end
    tick();
    checkOutput("to resp_valid", 64'(respValid), 64'(4'b1000));
    checkOutput("to resp_error", 64'(respError), 64'(1));
    checkOutput("to resp_data", 64'(respData), 64'(0));
    reqRead[3] = 1'b0;
    tick();
    checkOutput("to back idle", 64'(busy), 64'(0));
    applyStimulus(2, 1'b1, 1'b0, 4'hF, 32'h5000, 32'h0);
    serveOne(2, 32'hCAFEF00D, "after to");
    reqRead = 4'b0000;

    // mem_valid while idle is ignored.
    memValid = 1'b1;
    tick();
    memValid = 1'b0;
    checkOutput("idle mem_valid resp", 64'(respValid), 64'(0));
    checkOutput("idle mem_valid busy", 64'(busy), 64'(0));

    // Reset while in WAIT aborts silently; lowest requester then wins.
    applyStimulus(3, 1'b1, 1'b0, 4'hF, 32'h6000, 32'h0);
    tick();
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    reset = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h7000, 32'h0);
    reqRead[3] = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst resp_valid", 64'(respValid), 64'(0));
    checkOutput("rst grant", 64'(grant), 64'(0));
    checkOutput("rst busy", 64'(busy), 64'(0));
    checkOutput("rst mem_read", 64'(memRead), 64'(0));
    tick();
    checkOutput("rst first grant", 64'(grant), 64'(4'b0010));
    checkOutput("rst first address", 64'(memAddress), 64'(32'h7000));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
